// File: rtl/axil_mem_model_lat_pkg.sv
// Shared definitions for the latency-configurable AXI4-Lite memory model:
// response codes, channel FSM encodings, strobe decode and the latency LFSR step.
package axil_mem_model_lat_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_e;

    typedef enum logic [2:0] {
        W_IDLE    = 3'd0,
        W_HAVE_AW = 3'd1,
        W_HAVE_W  = 3'd2,
        W_WAIT    = 3'd3,
        W_RESP    = 3'd4
    } wr_state_e;

    // ok=1 with len=0 means an all-zero strobe (accepted, nothing written)
    typedef struct packed {
        logic       ok;
        logic [2:0] off;
        logic [3:0] len;
    } strb_info_t;

    function automatic strb_info_t strb_decode(input logic [7:0] strb);
        strb_info_t info;
        logic [7:0] m;
        info = '{ok: 1'b0, off: 3'd0, len: 4'd0};
        if (strb == 8'h00) begin
            info.ok = 1'b1;
        end else begin
            for (int l = 1; l <= 8; l = l * 2) begin
                for (int o = 0; o < 8; o = o + l) begin
                    m = 8'(((16'd1 << l) - 16'd1) << o);
                    if (strb == m) begin
                        info.ok  = 1'b1;
                        info.off = 3'(o);
                        info.len = 4'(l);
                    end else begin
                        info.ok = info.ok;
                    end
                end
            end
        end
        return info;
    endfunction

    // x^8 + x^6 + x^5 + x^4 + 1, shifting towards the MSB
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

endpackage

// File: rtl/axil_lat_lfsr.sv
// 8-bit latency LFSR; steps 0, 1 or 2 positions per cycle so a read and a
// write pairing in the same cycle each draw their own value.
module axil_lat_lfsr
    import axil_mem_model_lat_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] adv,
    input  logic [7:0] seed,
    output logic [7:0] lfsr
);

    logic [7:0] lfsr_r;

    // sequence register, reloaded with the seed on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_r <= seed;
        end else begin
            case (adv)
                2'd1:    lfsr_r <= lfsr_step(lfsr_r);
                2'd2:    lfsr_r <= lfsr_step(lfsr_step(lfsr_r));
                default: lfsr_r <= lfsr_r;
            endcase
        end
    end

    assign lfsr = lfsr_r;

endmodule

// File: rtl/axil_mem_model_lat.sv
// AXI4-Lite slave memory model with fixed or LFSR-driven per-transaction latency,
// window decode (DECERR) and strobe checking (SLVERR). Backing store is byte-lane RAM.
module axil_mem_model_lat
    import axil_mem_model_lat_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] MEM_BASE  = 32'h8000_0000,
    parameter logic [ADDR_W-1:0] MEM_SIZE  = 32'h0800_0000,
    parameter int                RAND_LAT  = 0,
    parameter int                R_LAT     = 1,
    parameter int                W_LAT     = 1,
    parameter int                MAX_LAT   = 8,
    parameter logic [7:0]        LFSR_SEED = 8'hA5,
    parameter int                BACK_AW   = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic                arvalid,
    output logic                arready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rvalid,
    input  logic                rready,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    output logic                wready,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready
);

    localparam int STRB_W  = DATA_W / 8;
    localparam int LANE_AW = $clog2(STRB_W);
    localparam int WORD_AW = BACK_AW - LANE_AW;

    rd_state_e rd_state_r, rd_state_s;
    wr_state_e wr_state_r, wr_state_s;
    logic [ADDR_W-1:0]  ar_addr_r, aw_addr_r, rd_addr_s, wr_addr_s;
    logic [DATA_W-1:0]  w_data_r, wr_data_s, rdata_r, rd_data_s, rd_mem_s;
    logic [STRB_W-1:0]  w_strb_r, wr_strb_s, lane_we_s;
    logic [WORD_AW-1:0] rd_word_s, wr_word_s;
    logic [7:0]         rd_cnt_r, wr_cnt_r, rd_lat_s, wr_lat_s, lfsr_s;
    logic [1:0]         rresp_r, bresp_r, wr_resp_s;
    logic               ar_hs_s, aw_hs_s, w_hs_s, wr_pair_s, rd_fire_s, wr_fire_s, wr_do_s;
    strb_info_t         wr_info_s;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] lo, hi, x;
        lo = {1'b0, MEM_BASE};
        hi = lo + {1'b0, MEM_SIZE};
        x  = {1'b0, a};
        return (x >= lo) && (x < hi);
    endfunction

    function automatic logic [7:0] rand_lat(input logic [7:0] v);
        return 8'(32'(v) % 32'(MAX_LAT)) + 8'd1;
    endfunction

    generate
        if (RAND_LAT != 0) begin : g_lfsr
            axil_lat_lfsr u_lfsr (
                .clk  (clk),
                .rst  (rst),
                .adv  ({1'b0, ar_hs_s} + {1'b0, wr_pair_s}),
                .seed (LFSR_SEED),
                .lfsr (lfsr_s)
            );
        end else begin : g_fixed
            assign lfsr_s = LFSR_SEED;
        end
    endgenerate

    assign arready = (rd_state_r == R_IDLE);
    assign rvalid  = (rd_state_r == R_RESP);
    assign awready = (wr_state_r == W_IDLE) || (wr_state_r == W_HAVE_W);
    assign wready  = (wr_state_r == W_IDLE) || (wr_state_r == W_HAVE_AW);
    assign bvalid  = (wr_state_r == W_RESP);
    assign rdata   = rdata_r;
    assign rresp   = rresp_r;
    assign bresp   = bresp_r;

    assign ar_hs_s   = arvalid && arready;
    assign aw_hs_s   = awvalid && awready;
    assign w_hs_s    = wvalid && wready;
    assign wr_pair_s = ((wr_state_r == W_IDLE) && aw_hs_s && w_hs_s) ||
                       ((wr_state_r == W_HAVE_AW) && w_hs_s) ||
                       ((wr_state_r == W_HAVE_W) && aw_hs_s);

    // a write pairing in the same cycle as an AR draws the LFSR's next value
    assign rd_lat_s = (RAND_LAT != 0) ? rand_lat(lfsr_s) : 8'(R_LAT);
    assign wr_lat_s = (RAND_LAT != 0) ? rand_lat(ar_hs_s ? lfsr_step(lfsr_s) : lfsr_s) : 8'(W_LAT);

    // A latency of 1 completes on the handshake edge itself, skipping the wait state
    assign rd_fire_s = (ar_hs_s && (rd_lat_s == 8'd1)) ||
                       ((rd_state_r == R_WAIT) && (rd_cnt_r == 8'd1));
    assign wr_fire_s = (wr_pair_s && (wr_lat_s == 8'd1)) ||
                       ((wr_state_r == W_WAIT) && (wr_cnt_r == 8'd1));

    assign rd_addr_s = (rd_state_r == R_IDLE) ? araddr : ar_addr_r;
    assign wr_addr_s = aw_hs_s ? awaddr : aw_addr_r;
    assign wr_data_s = w_hs_s ? wdata : w_data_r;
    assign wr_strb_s = w_hs_s ? wstrb : w_strb_r;
    assign rd_word_s = rd_addr_s[BACK_AW-1:LANE_AW];
    assign wr_word_s = wr_addr_s[BACK_AW-1:LANE_AW];
    assign wr_info_s = strb_decode(8'(wr_strb_s));
    assign wr_resp_s = !in_range(wr_addr_s) ? RESP_DECERR :
                       !wr_info_s.ok        ? RESP_SLVERR : RESP_OKAY;
    assign wr_do_s   = !rst && wr_fire_s && (wr_resp_s == RESP_OKAY) && (wr_info_s.len != 4'd0);

    // byte lanes covered by the (offset, length) run of a legal strobe
    always_comb begin
        lane_we_s = '0;
        for (int i = 0; i < STRB_W; i++) begin
            lane_we_s[i] = (4'(i) >= {1'b0, wr_info_s.off}) &&
                           (4'(i) < ({1'b0, wr_info_s.off} + wr_info_s.len));
        end
    end

    for (genvar g = 0; g < STRB_W; g++) begin : g_lane
        logic [7:0] mem_r [0:(2**WORD_AW)-1];

        // lane storage, only touched by committed writes; survives reset
        always_ff @(posedge clk) begin
            if (wr_do_s && lane_we_s[g]) begin
                mem_r[wr_word_s] <= wr_data_s[8*g +: 8];
            end
        end

        assign rd_mem_s[8*g +: 8] = mem_r[rd_word_s];
    end

    // a read committing alongside a write sees the freshly written bytes
    always_comb begin
        rd_data_s = rd_mem_s;
        for (int i = 0; i < STRB_W; i++) begin
            if (wr_do_s && lane_we_s[i] && (wr_word_s == rd_word_s)) begin
                rd_data_s[8*i +: 8] = wr_data_s[8*i +: 8];
            end else begin
                rd_data_s[8*i +: 8] = rd_mem_s[8*i +: 8];
            end
        end
    end

    // channel state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_r <= R_IDLE;
            wr_state_r <= W_IDLE;
        end else begin
            rd_state_r <= rd_state_s;
            wr_state_r <= wr_state_s;
        end
    end

    // read channel next state
    always_comb begin
        rd_state_s = rd_state_r;
        case (rd_state_r)
            R_IDLE: begin
                if (ar_hs_s) rd_state_s = rd_fire_s ? R_RESP : R_WAIT;
                else         rd_state_s = R_IDLE;
            end
            R_WAIT: begin
                if (rd_fire_s) rd_state_s = R_RESP;
                else           rd_state_s = R_WAIT;
            end
            R_RESP: begin
                if (rready) rd_state_s = R_IDLE;
                else        rd_state_s = R_RESP;
            end
            default: rd_state_s = R_IDLE;
        endcase
    end

    // write channel next state; AW and W may arrive in either order
    always_comb begin
        wr_state_s = wr_state_r;
        if (wr_pair_s) begin
            wr_state_s = wr_fire_s ? W_RESP : W_WAIT;
        end else begin
            case (wr_state_r)
                W_IDLE: begin
                    if (aw_hs_s)     wr_state_s = W_HAVE_AW;
                    else if (w_hs_s) wr_state_s = W_HAVE_W;
                    else             wr_state_s = W_IDLE;
                end
                W_HAVE_AW: wr_state_s = W_HAVE_AW;
                W_HAVE_W:  wr_state_s = W_HAVE_W;
                W_WAIT: begin
                    if (wr_fire_s) wr_state_s = W_RESP;
                    else           wr_state_s = W_WAIT;
                end
                W_RESP: begin
                    if (bready) wr_state_s = W_IDLE;
                    else        wr_state_s = W_RESP;
                end
                default: wr_state_s = W_IDLE;
            endcase
        end
    end

    // latched request fields, latency counters and registered responses
    always_ff @(posedge clk) begin
        if (rst) begin
            ar_addr_r <= '0;
            aw_addr_r <= '0;
            w_data_r  <= '0;
            w_strb_r  <= '0;
            rd_cnt_r  <= 8'd0;
            wr_cnt_r  <= 8'd0;
            rdata_r   <= '0;
            rresp_r   <= RESP_OKAY;
            bresp_r   <= RESP_OKAY;
        end else begin
            if (ar_hs_s) begin
                ar_addr_r <= araddr;
                rd_cnt_r  <= rd_lat_s - 8'd1;
            end else if (rd_state_r == R_WAIT) begin
                rd_cnt_r <= rd_cnt_r - 8'd1;
            end
            if (rd_fire_s) begin
                rdata_r <= in_range(rd_addr_s) ? rd_data_s : '0;
                rresp_r <= in_range(rd_addr_s) ? RESP_OKAY : RESP_DECERR;
            end
            if (aw_hs_s) begin
                aw_addr_r <= awaddr;
            end
            if (w_hs_s) begin
                w_data_r <= wdata;
                w_strb_r <= wstrb;
            end
            if (wr_pair_s) begin
                wr_cnt_r <= wr_lat_s - 8'd1;
            end else if (wr_state_r == W_WAIT) begin
                wr_cnt_r <= wr_cnt_r - 8'd1;
            end
            if (wr_fire_s) begin
                bresp_r <= wr_resp_s;
            end
        end
    end

endmodule

// File: tb/tb_axil_mem_model_lat.sv
// Directed plus randomized bench: instance 0 uses fixed latencies (R=3, W=2),
// instance 1 uses LFSR latencies (MAX_LAT=4); both checked against a byte-array model.
module tb_axil_mem_model_lat;

    logic        clk = 1'b0;
    logic        rst [2];
    logic [31:0] araddr [2], rdata [2], awaddr [2], wdata [2];
    logic        arvalid [2], arready [2], rvalid [2], rready [2];
    logic        awvalid [2], awready [2], wvalid [2], wready [2], bvalid [2], bready [2];
    logic [1:0]  rresp [2], bresp [2];
    logic [3:0]  wstrb [2];

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  ref_mem [2][4096];
    logic [7:0]  lfsr_m = 8'hA5;

    always #5 clk = ~clk;

    axil_mem_model_lat #(.R_LAT(3), .W_LAT(2)) dut0 (
        .clk(clk), .rst(rst[0]),
        .araddr(araddr[0]), .arvalid(arvalid[0]), .arready(arready[0]),
        .rdata(rdata[0]), .rresp(rresp[0]), .rvalid(rvalid[0]), .rready(rready[0]),
        .awaddr(awaddr[0]), .awvalid(awvalid[0]), .awready(awready[0]),
        .wdata(wdata[0]), .wstrb(wstrb[0]), .wvalid(wvalid[0]), .wready(wready[0]),
        .bresp(bresp[0]), .bvalid(bvalid[0]), .bready(bready[0])
    );

    axil_mem_model_lat #(.RAND_LAT(1), .MAX_LAT(4)) dut1 (
        .clk(clk), .rst(rst[1]),
        .araddr(araddr[1]), .arvalid(arvalid[1]), .arready(arready[1]),
        .rdata(rdata[1]), .rresp(rresp[1]), .rvalid(rvalid[1]), .rready(rready[1]),
        .awaddr(awaddr[1]), .awvalid(awvalid[1]), .awready(awready[1]),
        .wdata(wdata[1]), .wstrb(wstrb[1]), .wvalid(wvalid[1]), .wready(wready[1]),
        .bresp(bresp[1]), .bvalid(bvalid[1]), .bready(bready[1])
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_win(input logic [31:0] a);
        longint unsigned x;
        x = 64'(a);
        return (x >= 64'h8000_0000) && (x < 64'h8000_0000 + 64'h0800_0000);
    endfunction

    function automatic logic [1:0] exp_wresp(input logic [31:0] a, input logic [3:0] s);
        int n, lo;
        if (!in_win(a)) return 2'b11;
        if (s == 4'd0) return 2'b00;
        n  = $countones(s);
        lo = 0;
        while (s[lo] == 1'b0) lo++;
        if ((n == 1 || n == 2 || n == 4) && (lo % n == 0) && (int'(s) == (((1 << n) - 1) << lo)))
            return 2'b00;
        return 2'b10;
    endfunction

    function automatic logic [31:0] model_word(input int d, input logic [31:0] a);
        int b;
        b = int'(a[11:2]) * 4;
        return {ref_mem[d][b+3], ref_mem[d][b+2], ref_mem[d][b+1], ref_mem[d][b]};
    endfunction

    task automatic take_lat(input int d, input bit is_wr, output int lat);
        if (d == 0) begin
            lat = is_wr ? 2 : 3;
        end else begin
            lat    = int'(lfsr_m % 8'd4) + 1;
            lfsr_m = {lfsr_m[6:0], ^(lfsr_m & 8'hB8)};
        end
    endtask

    task automatic do_read(input int d, input logic [31:0] a, input string tag, output logic [31:0] obs);
        int el, c;
        logic [31:0] ed;
        take_lat(d, 1'b0, el);
        ed = in_win(a) ? model_word(d, a) : 32'd0;
        rready[d] = 1'b1; araddr[d] = a; arvalid[d] = 1'b1;
        step();
        arvalid[d] = 1'b0;
        c = 1;
        while (!rvalid[d] && c < 40) begin step(); c++; end
        chk({tag, "_rlat"}, 64'(c), 64'(el));
        chk({tag, "_rdata"}, 64'(rdata[d]), 64'(ed));
        chk({tag, "_rresp"}, 64'(rresp[d]), in_win(a) ? 64'd0 : 64'd3);
        obs = rdata[d];
        step();
    endtask

    // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W
    task automatic do_write(input int d, input logic [31:0] a, input logic [31:0] dt,
                            input logic [3:0] s, input int lead, input string tag);
        int el, c, t_aw, t_w, last;
        logic [1:0] er;
        take_lat(d, 1'b1, el);
        er   = exp_wresp(a, s);
        t_w  = (lead > 0) ? 0 : -lead;
        t_aw = (lead > 0) ? lead : 0;
        last = (t_aw > t_w) ? t_aw : t_w;
        bready[d] = 1'b1; awaddr[d] = a; wdata[d] = dt; wstrb[d] = s;
        for (int n = 0; n <= last; n++) begin
            awvalid[d] = (n == t_aw);
            wvalid[d]  = (n == t_w);
            step();
        end
        awvalid[d] = 1'b0; wvalid[d] = 1'b0;
        c = 1;
        while (!bvalid[d] && c < 40) begin step(); c++; end
        chk({tag, "_wlat"}, 64'(c), 64'(el));
        chk({tag, "_bresp"}, 64'(bresp[d]), 64'(er));
        if (er == 2'b00) begin
            for (int i = 0; i < 4; i++)
                if (s[i]) ref_mem[d][int'(a[11:2]) * 4 + i] = dt[8*i +: 8];
        end
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] obs, a, dt;
        int c;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; arvalid[d] = 1'b0; awvalid[d] = 1'b0; wvalid[d] = 1'b0;
            rready[d] = 1'b1; bready[d] = 1'b1;
            araddr[d] = 32'd0; awaddr[d] = 32'd0; wdata[d] = 32'd0; wstrb[d] = 4'd0;
        end
        step(); step();
        rst[0] = 1'b0; rst[1] = 1'b0;
        for (int k = 0; k < 10; k++) step();

        // 1: reset/idle state
        for (int d = 0; d < 2; d++) begin
            chk("t1_arready", 64'(arready[d]), 64'd1);
            chk("t1_awready", 64'(awready[d]), 64'd1);
            chk("t1_wready",  64'(wready[d]),  64'd1);
            chk("t1_rvalid",  64'(rvalid[d]),  64'd0);
            chk("t1_bvalid",  64'(bvalid[d]),  64'd0);
            chk("t1_rdata",   64'(rdata[d]),   64'd0);
            chk("t1_rresp",   64'(rresp[d]),   64'd0);
            chk("t1_bresp",   64'(bresp[d]),   64'd0);
        end

        // 2: fixed read latency 3
        do_write(0, 32'h8000_0010, 32'h1111_2222, 4'hF, 0, "t2_init");
        do_read(0, 32'h8000_0010, "t2", obs);

        // 3: W two cycles before AW, upper halfword
        do_write(0, 32'h8000_0020, 32'h1234_5678, 4'hF, -1, "t3_init");
        do_write(0, 32'h8000_0020, 32'hBEEF_0000, 4'b1100, 2, "t3");
        do_read(0, 32'h8000_0020, "t3_rb", obs);
        chk("t3_word", 64'(obs), 64'h0000_0000_BEEF_5678);

        // 4: illegal/empty strobes and decode boundaries
        do_write(0, 32'h8000_0020, 32'hAAAA_AAAA, 4'b0101, 1, "t4_slverr");
        do_write(0, 32'h8000_0020, 32'h5555_5555, 4'b0000, 0, "t4_zero");
        do_read(0, 32'h8000_0020, "t4_rb", obs);
        chk("t4_word", 64'(obs), 64'h0000_0000_BEEF_5678);
        do_read(0, 32'h7FFF_FFFC, "t4_below", obs);
        do_write(0, 32'h87FF_FFFC, 32'h0F0F_7777, 4'hF, 0, "t4_top");
        do_read(0, 32'h87FF_FFFC, "t4_top", obs);
        do_read(0, 32'h8800_0000, "t4_above", obs);
        do_write(0, 32'h8800_0000, 32'h1, 4'hF, 0, "t4_wdec");

        // 5: rready stall, second AR held off
        do_write(0, 32'h8000_0030, 32'hCAFE_F00D, 4'hF, 0, "t5_init0");
        do_write(0, 32'h8000_0034, 32'h0BAD_BEEF, 4'hF, -2, "t5_init1");
        rready[0] = 1'b0; araddr[0] = 32'h8000_0030; arvalid[0] = 1'b1;
        step();
        araddr[0] = 32'h8000_0034;
        c = 1;
        while (!rvalid[0] && c < 40) begin step(); c++; end
        chk("t5_lat", 64'(c), 64'd3);
        for (int k = 0; k < 5; k++) begin
            chk("t5_rvalid",  64'(rvalid[0]),  64'd1);
            chk("t5_rdata",   64'(rdata[0]),   64'h0000_0000_CAFE_F00D);
            chk("t5_arready", 64'(arready[0]), 64'd0);
            step();
        end
        rready[0] = 1'b1;
        step();
        chk("t5_idle", 64'(arready[0]), 64'd1);
        step();
        arvalid[0] = 1'b0;
        c = 1;
        while (!rvalid[0] && c < 40) begin step(); c++; end
        chk("t5_lat2", 64'(c), 64'd3);
        chk("t5_rdata2", 64'(rdata[0]), 64'h0000_0000_0BAD_BEEF);
        step();

        // 6: random latency instance
        for (int w = 0; w < 16; w++)
            do_write(1, 32'h8000_0100 + 32'(4 * w), $urandom, 4'hF, 0, "t6_init");
        for (int n = 0; n < 200; n++) begin
            a = 32'h8000_0100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) a = 32'h9000_0000 + 32'(4 * $urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0)
                do_read(1, a, "t6_rd", obs);
            else
                do_write(1, a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 4) - 2, "t6_wr");
        end
        while (lfsr_m % 8'd4 == 8'd0) do_read(1, 32'h8000_0100, "t6_pad", obs);
        dt = ~model_word(1, 32'h8000_0104);
        awaddr[1] = 32'h8000_0104; wdata[1] = dt; wstrb[1] = 4'hF;
        awvalid[1] = 1'b1; wvalid[1] = 1'b1;
        step();
        awvalid[1] = 1'b0; wvalid[1] = 1'b0;
        chk("t6_wait_bvalid", 64'(bvalid[1]), 64'd0);
        rst[1] = 1'b1;
        step();
        rst[1] = 1'b0;
        lfsr_m = 8'hA5;
        for (int k = 0; k < 4; k++) begin
            chk("t6_rst_bvalid", 64'(bvalid[1]), 64'd0);
            chk("t6_rst_awready", 64'(awready[1]), 64'd1);
            step();
        end
        do_read(1, 32'h8000_0104, "t6_after_rst", obs);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
